// File: rtl/calc_input_arbiter_pkg.sv
// calc_input_arbiter_pkg: shared state encoding, owner codes and character set
// for the calculator input arbiter.
package calc_input_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ISSUE,
        ST_GAP,
        ST_WAIT_RES,
        ST_FLUSH,
        ST_RELEASE
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_KP   = 2'd1;
    localparam logic [1:0] OWN_HS   = 2'd2;

    localparam logic [7:0] CH_0         = 8'h30;
    localparam logic [7:0] CH_9         = 8'h39;
    localparam logic [7:0] CH_PLUS      = 8'h2B;
    localparam logic [7:0] CH_MINUS     = 8'h2D;
    localparam logic [7:0] CH_MUL       = 8'h2A;
    localparam logic [7:0] CH_EQ        = 8'h3D;
    localparam logic [7:0] CH_CLR       = 8'h43;
    localparam logic [7:0] CH_BACKSPACE = 8'h08;

    function automatic logic is_legal(input logic [7:0] c);
        return (c >= CH_0 && c <= CH_9) || c == CH_PLUS || c == CH_MINUS || c == CH_MUL ||
               c == CH_EQ || c == CH_CLR || c == CH_BACKSPACE;
    endfunction

endpackage

// File: rtl/calc_input_arbiter_char_fifo.sv
// char_fifo: small 8-bit character FIFO; push is ignored while full, pop while empty.
module char_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/calc_input_arbiter.sv
// calc_input_arbiter: arbitrates keypad and host character streams onto the
// calculator's single button-strobe input and returns host results.
module calc_input_arbiter
    import calc_input_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kp_valid,
    input  logic [7:0]  kp_char,
    output logic        kp_ready,
    input  logic        hs_valid,
    input  logic [7:0]  hs_char,
    output logic        hs_ready,
    output logic        btn_valid,
    output logic [7:0]  btn_char,
    output logic        mode_sel,
    input  logic        result_valid,
    input  logic [31:0] result_value,
    output logic        hs_resp_valid,
    output logic [31:0] hs_resp_value,
    output logic [1:0]  owner
);
    localparam int CW = $clog2(IDLE_TIMEOUT + 1);

    state_t        state, state_nx;
    logic [1:0]    own_q, own_nx;
    logic          rr_q, rr_nx;
    logic [7:0]    last_q, last_nx;
    logic [CW-1:0] idle_q, idle_nx;
    logic          kp_full, kp_empty, hs_full, hs_empty, kp_pop, hs_pop;
    logic [7:0]    kp_head, hs_head, own_head;
    logic          own_empty, timeout;

    assign kp_ready = !kp_full;
    assign hs_ready = !hs_full;

    // Illegal characters still complete the handshake but never reach the FIFO.
    char_fifo #(.DEPTH(FIFO_DEPTH)) u_kp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (kp_valid && is_legal(kp_char)),
        .din   (kp_char),
        .pop   (kp_pop),
        .dout  (kp_head),
        .full  (kp_full),
        .empty (kp_empty)
    );

    char_fifo #(.DEPTH(FIFO_DEPTH)) u_hs_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (hs_valid && is_legal(hs_char)),
        .din   (hs_char),
        .pop   (hs_pop),
        .dout  (hs_head),
        .full  (hs_full),
        .empty (hs_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            own_q  <= OWN_NONE;
            rr_q   <= 1'b0;
            last_q <= '0;
            idle_q <= '0;
        end else begin
            state  <= state_nx;
            own_q  <= own_nx;
            rr_q   <= rr_nx;
            last_q <= last_nx;
            idle_q <= idle_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        own_nx    = own_q;
        rr_nx     = rr_q;
        last_nx   = last_q;
        kp_pop    = 1'b0;
        hs_pop    = 1'b0;
        btn_valid = 1'b0;
        btn_char  = '0;
        own_empty = (own_q == OWN_KP) ? kp_empty : hs_empty;
        own_head  = (own_q == OWN_KP) ? kp_head : hs_head;
        timeout   = idle_q == CW'(IDLE_TIMEOUT - 1);
        case (state)
            ST_IDLE: begin
                if (!kp_empty || !hs_empty) begin
                    // rr_q = 0 gives the keypad priority when both are waiting.
                    own_nx   = (!kp_empty && (hs_empty || !rr_q)) ? OWN_KP : OWN_HS;
                    state_nx = ST_GRANT;
                end
            end
            ST_GRANT: state_nx = ST_ISSUE;
            ST_ISSUE: begin
                if (!own_empty) begin
                    btn_valid = 1'b1;
                    btn_char  = own_head;
                    last_nx   = own_head;
                    kp_pop    = own_q == OWN_KP;
                    hs_pop    = own_q == OWN_HS;
                    state_nx  = ST_GAP;
                end else if (timeout) begin
                    state_nx = ST_FLUSH;
                end
            end
            ST_GAP: state_nx = (last_q == CH_EQ) ? ST_WAIT_RES : (last_q == CH_CLR) ? ST_RELEASE : ST_ISSUE;
            ST_WAIT_RES: state_nx = result_valid ? ST_RELEASE : timeout ? ST_FLUSH : ST_WAIT_RES;
            ST_FLUSH: begin
                btn_valid = 1'b1;
                btn_char  = CH_CLR;
                state_nx  = ST_RELEASE;
            end
            ST_RELEASE: begin
                rr_nx    = own_q == OWN_KP;
                own_nx   = OWN_NONE;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // The timeout can never be passed: reaching it always changes state, which clears the count.
        idle_nx = (state_nx != state || btn_valid) ? '0 :
                  (state == ST_ISSUE || state == ST_WAIT_RES) ? idle_q + 1'b1 : '0;
    end

    assign owner         = (state == ST_IDLE || state == ST_RELEASE) ? OWN_NONE : own_q;
    assign mode_sel      = owner != OWN_NONE;
    assign hs_resp_valid = state == ST_WAIT_RES && result_valid && own_q == OWN_HS;
    assign hs_resp_value = hs_resp_valid ? result_value : '0;

endmodule

// File: tb/tb_calc_input_arbiter.sv
// tb_calc_input_arbiter: directed scenarios plus randomized traffic scored
// against a queue-based model of the two character sources.
module tb_calc_input_arbiter;
    localparam int DEPTH = 4;
    localparam int TMO   = 1000;

    logic        clk = 0, rst_n = 0;
    logic        kp_valid = 0, hs_valid = 0, result_valid = 0;
    logic [7:0]  kp_char = 0, hs_char = 0;
    logic [31:0] result_value = 0;
    logic        kp_ready, hs_ready, btn_valid, mode_sel, hs_resp_valid;
    logic [7:0]  btn_char;
    logic [31:0] hs_resp_value;
    logic [1:0]  owner;

    int checks = 0, errors = 0;

    logic [7:0]  btn_q[$];
    logic [1:0]  bown_q[$];
    int          bcyc_q[$];
    int          cyc = 0, resp_cnt = 0, b2b_viol = 0, mode_viol = 0, quiet = 0;
    logic [31:0] resp_last = 0;
    bit          prev_btn = 0;

    bit          sb_on = 0, awaiting = 0, eq_flag = 0;
    bit          resp_en = 1, spur_en = 0, rand_vals = 0;
    logic [1:0]  await_own = 0, eq_own = 0;
    logic [7:0]  kq[$], hq[$];
    int          timer = 0, hold = 0;

    string       s;
    logic [1:0]  own_s[5];
    logic        ms_s[5], bv_s[5];
    logic [7:0]  bc_s[5];
    int          d, rdy_hi, kr, hr;
    bit          r;

    always #5 clk = ~clk;

    calc_input_arbiter #(.FIFO_DEPTH(DEPTH), .IDLE_TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .kp_valid      (kp_valid),
        .kp_char       (kp_char),
        .kp_ready      (kp_ready),
        .hs_valid      (hs_valid),
        .hs_char       (hs_char),
        .hs_ready      (hs_ready),
        .btn_valid     (btn_valid),
        .btn_char      (btn_char),
        .mode_sel      (mode_sel),
        .result_valid  (result_valid),
        .result_value  (result_value),
        .hs_resp_valid (hs_resp_valid),
        .hs_resp_value (hs_resp_value),
        .owner         (owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit legal_ch(input logic [7:0] c);
        return (c >= "0" && c <= "9") || c == "+" || c == "-" || c == "*" || c == "=" || c == "C" || c == 8'h08;
    endfunction

    function automatic logic [7:0] pick();
        string tbl = "0123456789+-*=C";
        int    k   = $urandom_range(0, 17);
        return k < 15 ? tbl[k] : k == 15 ? 8'h08 : k == 16 ? "x" : "!";
    endfunction

    // Reference model: one queue per source, a pending-result flag, and a quiet-cycle count.
    task automatic score();
        bit         kacc, hacc, exp_hs, have, flush;
        logic [7:0] front;
        check("kp_ready", kp_ready, kq.size() < DEPTH);
        check("hs_ready", hs_ready, hq.size() < DEPTH);
        exp_hs = awaiting && result_valid && await_own == 2;
        check("hs_resp_valid", hs_resp_valid, exp_hs);
        if (exp_hs) check("hs_resp_value", hs_resp_value, result_value);
        if (awaiting && result_valid) awaiting = 0;
        kacc = kp_valid && kq.size() < DEPTH && legal_ch(kp_char);
        hacc = hs_valid && hq.size() < DEPTH && legal_ch(hs_char);
        if (btn_valid) begin
            check("btn_owner", owner != 0, 1);
            have  = (owner == 1) ? kq.size() > 0 : hq.size() > 0;
            front = !have ? 8'h00 : (owner == 1) ? kq[0] : hq[0];
            flush = btn_char == "C" && (!have || front != "C" || quiet > 64);
            if (flush) begin
                check("flush_quiet", quiet >= TMO, 1);
            end else begin
                check("btn_char", btn_char, front);
                if (have && owner == 1) void'(kq.pop_front());
                else if (have) void'(hq.pop_front());
                if (front == "=") begin
                    awaiting  = 1;
                    await_own = owner;
                end
            end
        end
        if (kacc) kq.push_back(kp_char);
        if (hacc) hq.push_back(hs_char);
        quiet = (btn_valid || owner == 0) ? 0 : quiet + 1;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_btn = 0;
        end else begin
            if (btn_valid) begin
                btn_q.push_back(btn_char);
                bown_q.push_back(owner);
                bcyc_q.push_back(cyc);
            end
            if (btn_valid && prev_btn) b2b_viol++;
            prev_btn = btn_valid;
            if (mode_sel != (owner != 0)) mode_viol++;
            if (hs_resp_valid) begin
                resp_cnt++;
                resp_last = hs_resp_value;
            end
            if (btn_valid && btn_char == "=") begin
                eq_flag = 1;
                eq_own  = owner;
            end
            if (sb_on) score();
        end
    end

    // Calculator stand-in: answers each '=' after a few cycles, optionally with stray result pulses.
    always begin
        @(posedge clk);
        #2;
        if (!rst_n || !resp_en) begin
            result_valid = 0;
            timer = 0;
            hold = 0;
            eq_flag = 0;
        end else begin
            if (hold > 0) begin
                hold--;
                if (hold == 0) result_valid = 0;
            end
            if (eq_flag) begin
                eq_flag = 0;
                timer = $urandom_range(3, 10);
            end else if (timer > 0) begin
                timer--;
                if (timer == 0) begin
                    result_valid = 1;
                    result_value = rand_vals ? $urandom : (eq_own == 2 ? 32'd42 : 32'd15);
                    hold = $urandom_range(1, 3);
                end
            end else if (spur_en && hold == 0 && !awaiting && $urandom_range(0, 40) == 0) begin
                result_valid = 1;
                result_value = $urandom;
                hold = 1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        btn_q.delete();
        bown_q.delete();
        bcyc_q.delete();
        resp_cnt = 0;
    endtask

    task automatic do_reset();
        kp_valid = 0;
        hs_valid = 0;
        rst_n = 0;
        tick(3);
        rst_n = 1;
        awaiting = 0;
        kq.delete();
        hq.delete();
        tick(1);
        clear_log();
    endtask

    task automatic push_both(input logic [7:0] kc, input bit kv, input logic [7:0] hc, input bit hv);
        kp_valid = kv;
        kp_char  = kc;
        hs_valid = hv;
        hs_char  = hc;
        tick(1);
        kp_valid = 0;
        hs_valid = 0;
    endtask

    task automatic wait_btns(input int n, input int budget, input string tag);
        int c = 0;
        while (btn_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_btn_count"}, btn_q.size() >= n, 1);
    endtask

    task automatic wait_free(input int budget, input string tag);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (owner != 0 && c < budget);
        check({tag, "_released"}, owner, 0);
        tick(1);
    endtask

    task automatic expect_seq(input string tag, input string e, input logic [1:0] own);
        for (int i = 0; i < e.len(); i++) begin
            if (btn_q.size() == 0) begin
                check({tag, "_missing"}, 0, 1);
                return;
            end
            check(tag, btn_q.pop_front(), e[i]);
            check({tag, "_own"}, bown_q.pop_front(), own);
            void'(bcyc_q.pop_front());
        end
    endtask

    task automatic offer_hs(input logic [7:0] c, input int budget);
        int k = 0;
        hs_valid = 1;
        hs_char  = c;
        do begin
            @(negedge clk);
            r = hs_ready;
            tick(1);
            k++;
        end while (!r && k < budget);
        check("hs_offer_accepted", r, 1);
        hs_valid = 0;
    endtask

    initial begin
        do_reset();
        check("rst_btn_valid", btn_valid, 0);
        check("rst_btn_char", btn_char, 0);
        check("rst_mode_sel", mode_sel, 0);
        check("rst_owner", owner, 0);
        check("rst_hs_resp_valid", hs_resp_valid, 0);
        check("rst_hs_resp_value", hs_resp_value, 0);
        check("rst_kp_ready", kp_ready, 1);
        check("rst_hs_ready", hs_ready, 1);

        // Keypad expression with exact grant/issue timing.
        s = "12+3=";
        for (int i = 0; i < 5; i++) begin
            kp_valid = 1;
            kp_char  = s[i];
            @(negedge clk);
            own_s[i] = owner;
            ms_s[i]  = mode_sel;
            bv_s[i]  = btn_valid;
            bc_s[i]  = btn_char;
            tick(1);
        end
        kp_valid = 0;
        check("kp_idle_owner", own_s[1], 0);
        check("kp_grant_owner", own_s[2], 1);
        check("kp_grant_mode", ms_s[2], 1);
        check("kp_grant_nobtn", bv_s[2], 0);
        check("kp_issue_btn", bv_s[3], 1);
        check("kp_issue_char", bc_s[3], "1");
        check("kp_gap_nobtn", bv_s[4], 0);
        wait_btns(5, 200, "kp");
        wait_free(100, "kp");
        expect_seq("kp_seq", "12+3=", 1);
        check("kp_no_hs_resp", resp_cnt, 0);

        // Simultaneous load: keypad first, then host; then host wins after a keypad turn.
        do_reset();
        push_both("1", 1, "2", 1);
        push_both("=", 1, "=", 1);
        wait_btns(4, 300, "rr1");
        wait_free(100, "rr1");
        expect_seq("rr1_kp", "1=", 1);
        expect_seq("rr1_hs", "2=", 2);
        check("rr1_resp_cnt", resp_cnt, 1);
        push_both("3", 1, 0, 0);
        push_both("=", 1, 0, 0);
        wait_btns(2, 200, "rr2a");
        wait_free(100, "rr2a");
        push_both("4", 1, "5", 1);
        push_both("=", 1, "=", 1);
        wait_btns(6, 300, "rr2");
        wait_free(100, "rr2");
        expect_seq("rr2_kp_solo", "3=", 1);
        expect_seq("rr2_hs_first", "5=", 2);
        expect_seq("rr2_kp_second", "4=", 1);

        // Idle timeout flush.
        do_reset();
        push_both("5", 1, 0, 0);
        wait_btns(1, 20, "to_first");
        wait_btns(2, TMO + 100, "to_flush");
        d = (bcyc_q.size() >= 2) ? bcyc_q[1] - bcyc_q[0] : 0;
        check("to_delay_in_range", d >= TMO + 1 && d <= TMO + 3, 1);
        wait_free(10, "to");
        expect_seq("to_seq", "5C", 1);

        // Host fills its FIFO while keypad owns; illegal 'x' is consumed and dropped.
        do_reset();
        push_both("1", 1, 0, 0);
        wait_btns(1, 20, "full_kp");
        offer_hs("x", 5);
        offer_hs("7", 5);
        offer_hs("*", 5);
        offer_hs("6", 5);
        offer_hs("=", 5);
        hs_valid = 1;
        hs_char  = "C";
        rdy_hi   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rdy_hi += hs_ready;
            tick(1);
        end
        check("full_hs_ready_low", rdy_hi, 0);
        kp_valid = 1;
        kp_char  = "=";
        tick(1);
        kp_valid = 0;
        offer_hs("C", 200);
        wait_btns(7, 400, "full");
        wait_free(100, "full");
        expect_seq("full_kp_seq", "1=", 1);
        expect_seq("full_hs_seq", "7*6=C", 2);
        check("hs_resp_cnt", resp_cnt, 1);
        check("hs_resp_value42", resp_last, 42);

        // Reset while waiting for a result.
        do_reset();
        resp_en = 0;
        push_both("8", 1, 0, 0);
        push_both("=", 1, 0, 0);
        wait_btns(2, 50, "rstmid");
        tick(3);
        check("rstmid_in_wait", owner, 1);
        rst_n = 0;
        #1;
        check("rstmid_owner", owner, 0);
        check("rstmid_mode", mode_sel, 0);
        check("rstmid_btn_valid", btn_valid, 0);
        check("rstmid_btn_char", btn_char, 0);
        check("rstmid_hs_resp", hs_resp_valid, 0);
        tick(3);
        rst_n = 1;
        tick(20);
        check("rstmid_no_clear", btn_q.size(), 2);
        check("rstmid_kp_ready", kp_ready, 1);
        check("rstmid_hs_ready", hs_ready, 1);
        resp_en = 1;

        // Randomized traffic against the queue model.
        do_reset();
        spur_en   = 1;
        rand_vals = 1;
        sb_on     = 1;
        for (int c = 0; c < 20000; c++) begin
            if (c % 400 == 0) begin
                kr = $urandom_range(0, 90);
                hr = $urandom_range(0, 90);
            end
            kp_valid = $urandom_range(0, 99) < kr;
            kp_char  = pick();
            hs_valid = $urandom_range(0, 99) < hr;
            hs_char  = pick();
            tick(1);
        end
        kp_valid = 0;
        hs_valid = 0;
        tick(2);
        sb_on = 0;

        check("no_back_to_back_btn", b2b_viol, 0);
        check("mode_sel_tracks_owner", mode_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_input_arbiter.md
CALC_INPUT_ARBITER -- requirements
Module: calc_input_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: entries per source character FIFO (power of 2).
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 1000: cycles without owner activity before forced release.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports kp_valid/kp_char  input  1/8  keypad character offer; kp_ready  output  1  keypad FIFO not full.
REQ-006 SHALL have ports hs_valid/hs_char  input  1/8  host (UART) character offer; hs_ready  output  1  host FIFO not full.
REQ-007 SHALL have ports btn_valid/btn_char  output  1/8  single-cycle character strobe to calculator; mode_sel  output  1  calculator mode (1 = direct input).
REQ-008 SHALL have ports result_valid/result_value  input  1/32  calculator result level and value.
REQ-009 SHALL have ports hs_resp_valid/hs_resp_value  output  1/32  one-cycle result pulse to host; owner  output  2  0 none, 1 keypad, 2 host.

Function
REQ-010 SHALL accept a character on valid && ready; legal set '0'-'9', '+', '-', '*', '=', 'C', 8'h08; illegal characters consumed and dropped, not stored.
REQ-011 SHALL support simultaneous push and pop on one FIFO in one cycle; ready = not full, evaluated before the pop.
REQ-012 SHALL implement states IDLE, GRANT, ISSUE, GAP, WAIT_RES, FLUSH, RELEASE.
REQ-013 IDLE: mode_sel=0, owner=0; if any FIFO non-empty, grant next cycle -> GRANT; both non-empty -> round robin, keypad wins first after reset.
REQ-014 GRANT: drive mode_sel=1 and owner; hold one cycle (calculator clears on 0->1 edge) -> ISSUE.
REQ-015 ISSUE: if owner FIFO non-empty, pop head, pulse btn_valid with btn_char for exactly one cycle -> GAP; else remain, increment idle counter.
REQ-016 GAP: one cycle, btn_valid=0; next: issued char '=' -> WAIT_RES, 'C' -> RELEASE, else -> ISSUE.
REQ-017 WAIT_RES: on first cycle result_valid=1 -> RELEASE; if owner is host, pulse hs_resp_valid one cycle with result_value captured that cycle.
REQ-018 Idle counter: reset on every issued char and on state entry; reaching IDLE_TIMEOUT in ISSUE or WAIT_RES -> FLUSH.
REQ-019 FLUSH: pulse btn_valid with 'C' one cycle -> RELEASE; remaining FIFO contents of owner untouched.
REQ-020 RELEASE: one cycle, mode_sel=0, owner=0, round-robin pointer points to non-owner -> IDLE.
REQ-021 Non-owner FIFO SHALL keep accepting while full not reached; never popped while not owner.
REQ-022 btn_valid SHALL never assert on two consecutive cycles; at most one btn_valid per ISSUE/FLUSH visit.
REQ-023 result_valid asserted outside WAIT_RES SHALL be ignored (no hs_resp_valid).

Reset
REQ-024 On rst_n low: state IDLE, FIFOs empty, btn_valid=0, btn_char=0, mode_sel=0, owner=0, hs_resp_valid=0, hs_resp_value=0, idle counter 0, round robin to keypad.
REQ-025 Reset mid-transaction SHALL abort immediately with no 'C' emitted; ready outputs become 1 after deassertion.

Structure
REQ-026 Shared package SHALL hold state encoding, owner codes, legal character constants (incl. BACKSPACE 8'h08) and the legality check function.
REQ-027 One sub-module char_fifo (parameter depth, 8-bit, push/pop/full/empty) instantiated twice.

Verification
REQ-028 Keypad "1","2","+","3","=", result 15 -> btn pulses 12+3= with gaps, mode_sel 1 from GRANT, released after result_valid; no hs_resp_valid.
REQ-029 Host "7","*","6","=", result 42 -> hs_resp_valid one cycle with hs_resp_value 42, owner=2 during transaction.
REQ-030 Both FIFOs loaded same cycle after reset -> keypad served first, host granted next after RELEASE; swap order on second round.
REQ-031 Keypad "5" only, no further input -> after 1000 idle cycles 'C' pulse, owner returns 0.
REQ-032 Host pushes 5 chars with no pop while keypad owns -> hs_ready low after 4, fifth held until pop; illegal 'x' dropped.
REQ-033 rst_n low during WAIT_RES -> all outputs reset values next edge, no 'C' emitted.
